clk_div_monitor: RTL and testbench

//   Checks the divided-clock outputs of the clock divider, which produces
//   clk_div2, clk_div4 and clk_div8.
//   All three are sampled as data in the clk domain. The block measures the

---
 rtl/clk_div_monitor_if.sv | 23 ++
 rtl/clk_div_monitor.sv | 155 +++++++++++++++
 tb/tb_clk_div_monitor.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/clk_div_monitor_if.sv
// Bundle between a 2/4/8 clock divider and its period monitor: divided clocks
// and error-clear flow into the monitor, lock and error status flow back.
interface clk_div_monitor_if #(
  parameter int CNT_W = 8
);
  logic             clk_div2;
  logic             clk_div4;
  logic             clk_div8;
  logic             clr_err;
  logic             locked;
  logic [2:0]       err_sticky;
  logic [CNT_W-1:0] err_count;

  modport master (
    output clk_div2, clk_div4, clk_div8, clr_err,
    input  locked, err_sticky, err_count
  );

  modport slave (
    input  clk_div2, clk_div4, clk_div8, clr_err,
    output locked, err_sticky, err_count
  );
endinterface

// File: rtl/clk_div_monitor.sv
// Period monitor for the divide-by-2/4/8 outputs: samples them in the clk
// domain, checks each rise-to-rise period, reports lock and sticky errors.
module clk_div_monitor #(
  parameter int LOCK_COUNT = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  clk_div_monitor_if.slave bus
);

  localparam int         NCH      = 3;
  localparam logic [3:0] LOCK_VAL = 4'(LOCK_COUNT);
  localparam logic [4:0] PER_MAX  = 5'd31;

  logic [NCH-1:0]      in_s;
  logic [NCH-1:0]      q_r;
  logic [NCH-1:0]      q_d_r;
  logic [NCH-1:0]      rise_s;
  logic [NCH-1:0]      armed_r;
  logic [NCH-1:0]      armed_nxt_s;
  logic [NCH-1:0][4:0] per_cnt_r;
  logic [NCH-1:0][4:0] per_cnt_nxt_s;
  logic [NCH-1:0][3:0] good_cnt_r;
  logic [NCH-1:0][3:0] good_cnt_nxt_s;
  logic [NCH-1:0]      bad_s;
  logic                locked_r;
  logic                locked_nxt_s;
  logic [NCH-1:0]      err_sticky_r;
  logic [NCH-1:0]      err_sticky_nxt_s;
  logic [CNT_W-1:0]    err_count_r;
  logic [CNT_W-1:0]    err_count_nxt_s;
  logic [CNT_W-1:0]    err_base_s;

  function automatic logic [4:0] exp_period(input logic [1:0] ch);
    logic [4:0] p;
    case (ch)
      2'd0:    p = 5'd2;
      2'd1:    p = 5'd4;
      2'd2:    p = 5'd8;
      default: p = 5'd8;
    endcase
    return p;
  endfunction

  // A channel that has waited 2*EXP+1 cycles without a rise is declared stuck.
  function automatic logic [4:0] timeout_period(input logic [1:0] ch);
    logic [4:0] p;
    p = exp_period(ch);
    return {p[3:0], 1'b0} + 5'd1;
  endfunction

  function automatic logic [4:0] per_inc(input logic [4:0] p);
    return (p == PER_MAX) ? PER_MAX : p + 5'd1;
  endfunction

  function automatic logic [3:0] good_inc(input logic [3:0] g);
    return (g >= LOCK_VAL) ? LOCK_VAL : g + 4'd1;
  endfunction

  assign in_s   = {bus.clk_div8, bus.clk_div4, bus.clk_div2};
  assign rise_s = q_r & ~q_d_r;

  // Two-stage sampler of the divided clocks for rise detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_r   <= 3'b000;
      q_d_r <= 3'b000;
    end else begin
      q_r   <= in_s;
      q_d_r <= q_r;
    end
  end

  // Per-channel arm / period-check / timeout decisions.
  always_comb begin
    armed_nxt_s    = armed_r;
    per_cnt_nxt_s  = per_cnt_r;
    good_cnt_nxt_s = good_cnt_r;
    bad_s          = 3'b000;
    for (int ch = 0; ch < NCH; ch++) begin
      if (!armed_r[ch]) begin
        if (rise_s[ch]) begin
          armed_nxt_s[ch]   = 1'b1;
          per_cnt_nxt_s[ch] = 5'd1;
        end else begin
          per_cnt_nxt_s[ch] = per_cnt_r[ch];
        end
      end else if (rise_s[ch]) begin
        per_cnt_nxt_s[ch] = 5'd1;
        if (per_cnt_r[ch] == exp_period(2'(ch))) begin
          good_cnt_nxt_s[ch] = good_inc(good_cnt_r[ch]);
        end else begin
          bad_s[ch]          = 1'b1;
          good_cnt_nxt_s[ch] = 4'd0;
        end
      end else begin
        per_cnt_nxt_s[ch] = per_inc(per_cnt_r[ch]);
        // Disarming after the timeout keeps a stuck input to a single event.
        if (per_inc(per_cnt_r[ch]) == timeout_period(2'(ch))) begin
          bad_s[ch]          = 1'b1;
          armed_nxt_s[ch]    = 1'b0;
          good_cnt_nxt_s[ch] = 4'd0;
        end else begin
          armed_nxt_s[ch]    = 1'b1;
        end
      end
    end
  end

  // Per-channel state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      armed_r    <= 3'b000;
      per_cnt_r  <= {NCH{5'd0}};
      good_cnt_r <= {NCH{4'd0}};
    end else begin
      armed_r    <= armed_nxt_s;
      per_cnt_r  <= per_cnt_nxt_s;
      good_cnt_r <= good_cnt_nxt_s;
    end
  end

  // Status next-values; a bad event coinciding with clr_err survives the clear.
  always_comb begin
    locked_nxt_s     = (good_cnt_nxt_s[0] == LOCK_VAL) &&
                       (good_cnt_nxt_s[1] == LOCK_VAL) &&
                       (good_cnt_nxt_s[2] == LOCK_VAL);
    err_sticky_nxt_s = (bus.clr_err ? 3'b000 : err_sticky_r) | bad_s;
    err_base_s       = bus.clr_err ? {CNT_W{1'b0}} : err_count_r;
    if ((|bad_s) && (err_base_s != {CNT_W{1'b1}})) begin
      err_count_nxt_s = err_base_s + CNT_W'(1'b1);
    end else begin
      err_count_nxt_s = err_base_s;
    end
  end

  // Registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      locked_r     <= 1'b0;
      err_sticky_r <= 3'b000;
      err_count_r  <= {CNT_W{1'b0}};
    end else begin
      locked_r     <= locked_nxt_s;
      err_sticky_r <= err_sticky_nxt_s;
      err_count_r  <= err_count_nxt_s;
    end
  end

  assign bus.locked     = locked_r;
  assign bus.err_sticky = err_sticky_r;
  assign bus.err_count  = err_count_r;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Directed bench for clk_div_monitor: ideal waveforms from a phase counter,
// with forced channels / phase shifts for error cases; second DUT has CNT_W=2.
module tb_clk_div_monitor;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   k      = 0;
  int   off4   = 0;

  typedef struct {
    int         cycles;
    logic [2:0] fmask;
    logic [2:0] fval;
    logic       clr;
    logic       exp_locked;
    logic [2:0] exp_sticky;
    int         exp_count;
  } vec_t;

  vec_t vecs [5];

  clk_div_monitor_if #(.CNT_W(8)) bus ();
  clk_div_monitor_if #(.CNT_W(2)) bus2 ();

  assign bus2.clk_div2 = bus.clk_div2;
  assign bus2.clk_div4 = bus.clk_div4;
  assign bus2.clk_div8 = bus.clk_div8;
  assign bus2.clr_err  = bus.clr_err;

  clk_div_monitor #(.LOCK_COUNT(4), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  clk_div_monitor #(.LOCK_COUNT(4), .CNT_W(2)) dut_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // One cycle: drive at negedge, return just after the posedge that samples it.
  task automatic drive(input logic [2:0] fmask, input logic [2:0] fval, input logic clr);
    logic [2:0] w;
    int         k4;
    @(negedge clk);
    k4 = k - off4;
    w  = {k[2], k4[1], k[0]};
    w  = (w & ~fmask) | (fval & fmask);
    bus.clk_div2 = w[0];
    bus.clk_div4 = w[1];
    bus.clk_div8 = w[2];
    bus.clr_err  = clr;
    k++;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) drive(3'b000, 3'b000, 1'b0);
  endtask

  task automatic check(input string name, input logic exp_locked,
                       input logic [2:0] exp_sticky, input int exp_count);
    int exp2;
    exp2 = (exp_count > 3) ? 3 : exp_count;
    checks++;
    if (bus.locked !== exp_locked) begin
      errors++;
      $display("FAIL %s locked: got %0b expected %0b", name, bus.locked, exp_locked);
    end
    checks++;
    if (bus.err_sticky !== exp_sticky) begin
      errors++;
      $display("FAIL %s err_sticky: got %03b expected %03b", name, bus.err_sticky, exp_sticky);
    end
    checks++;
    if (bus.err_count !== 8'(exp_count)) begin
      errors++;
      $display("FAIL %s err_count: got %0d expected %0d", name, bus.err_count, exp_count);
    end
    checks++;
    if (bus2.err_count !== 2'(exp2)) begin
      errors++;
      $display("FAIL %s err_count(CNT_W=2): got %0d expected %0d", name, bus2.err_count, exp2);
    end
  endtask

  task automatic apply_table(input string tag);
    for (int i = 0; i < 5; i++) begin
      repeat (vecs[i].cycles) drive(vecs[i].fmask, vecs[i].fval, vecs[i].clr);
      check($sformatf("%s_vec%0d", tag, i), vecs[i].exp_locked,
            vecs[i].exp_sticky, vecs[i].exp_count);
    end
  endtask

  // Make div2 period 4 once (forced high for one extra cycle), then let it relock.
  task automatic glitch_div2(input string name, input logic clr,
                             input logic [2:0] exp_sticky, input int exp_count);
    while ((k & 1) != 0) drive(3'b000, 3'b000, 1'b0);
    drive(3'b001, 3'b001, 1'b0);
    run(3);
    drive(3'b000, 3'b000, clr);
    check({name, "_bad"}, 1'b0, exp_sticky, exp_count);
    run(7);
    check({name, "_pending"}, 1'b0, exp_sticky, exp_count);
    run(1);
    check({name, "_relock"}, 1'b1, exp_sticky, exp_count);
  endtask

  initial begin
    // Clean run from reset; div8 lock lands on the edge after k=36 is captured.
    vecs[0] = '{32'd2,  3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 32'd0};
    vecs[1] = '{32'd28, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 32'd0};
    vecs[2] = '{32'd7,  3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 32'd0};
    vecs[3] = '{32'd1,  3'b000, 3'b000, 1'b0, 1'b1, 3'b000, 32'd0};
    vecs[4] = '{32'd20, 3'b000, 3'b000, 1'b1, 1'b1, 3'b000, 32'd0};

    reset        = 1'b1;
    bus.clk_div2 = 1'b0;
    bus.clk_div4 = 1'b0;
    bus.clk_div8 = 1'b0;
    bus.clr_err  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 1'b0, 3'b000, 0);
    @(negedge clk);
    reset = 1'b0;

    apply_table("clean");

    // div4 high phase stretched: that period is 5, later ones 4 again.
    while (((k - off4) & 3) != 0) drive(3'b000, 3'b000, 1'b0);
    off4 = off4 + 1;
    drive(3'b000, 3'b000, 1'b0);
    run(3);
    check("div4_before_bad", 1'b1, 3'b000, 0);
    run(1);
    check("div4_stretch_bad", 1'b0, 3'b010, 1);
    run(15);
    check("div4_relock_pending", 1'b0, 3'b010, 1);
    run(1);
    check("div4_relock", 1'b1, 3'b010, 1);

    // div8 held low for 56 cycles from a falling point.
    while ((k & 7) != 0) drive(3'b000, 3'b000, 1'b0);
    repeat (13) drive(3'b100, 3'b000, 1'b0);
    check("div8_stuck_before_timeout", 1'b1, 3'b010, 1);
    drive(3'b100, 3'b000, 1'b0);
    check("div8_timeout", 1'b0, 3'b110, 2);
    repeat (42) drive(3'b100, 3'b000, 1'b0);
    check("div8_stuck_single_event", 1'b0, 3'b110, 2);
    run(37);
    check("div8_relock_pending", 1'b0, 3'b110, 2);
    run(1);
    check("div8_relock", 1'b1, 3'b110, 2);

    glitch_div2("clr_prep", 1'b0, 3'b111, 3);
    glitch_div2("clr_same_cycle", 1'b1, 3'b001, 1);
    for (int n = 2; n <= 5; n++) begin
      glitch_div2($sformatf("sat_event%0d", n), 1'b0, 3'b001, n);
    end

    // Asynchronous reset between edges while locked with errors recorded.
    @(negedge clk);
    #2;
    reset        = 1'b1;
    bus.clk_div2 = 1'b0;
    bus.clk_div4 = 1'b0;
    bus.clk_div8 = 1'b0;
    bus.clr_err  = 1'b0;
    #1;
    check("reset_async", 1'b0, 3'b000, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    k     = 0;
    off4  = 0;
    apply_table("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
